// File: rtl/block_mem_responder_pkg.sv
// Shared types and default geometry for the block memory responder.
package mem_pkg;

  localparam int DEF_WORD_W       = 32;
  localparam int DEF_BLOCK_WORDS  = 4;
  localparam int DEF_BLOCK_ADDR_W = 8;
  localparam int DEF_LATENCY      = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef logic [DEF_WORD_W*DEF_BLOCK_WORDS-1:0] block_t;

endpackage

// File: rtl/block_mem_responder_word_array.sv
// Single-port synchronous word RAM: one read or one write per cycle, registered read data.
module mem_word_array #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

  // Backdoor load of array contents, called hierarchically from simulation.
  task preload(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    mem[a] <= d;
  endtask

endmodule

// File: rtl/block_mem_responder.sv
// Block refill / write-back responder: one request at a time, fixed-latency ACCESS, one-cycle response pulse.
module block_mem_responder
  import mem_pkg::*;
#(
  parameter int WORD_W       = DEF_WORD_W,
  parameter int BLOCK_WORDS  = DEF_BLOCK_WORDS,
  parameter int BLOCK_ADDR_W = DEF_BLOCK_ADDR_W,
  parameter int LATENCY      = DEF_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [BLOCK_ADDR_W-1:0]       req_addr,
  input  logic [WORD_W*BLOCK_WORDS-1:0] req_wdata,
  output logic                          resp_valid,
  output logic [WORD_W*BLOCK_WORDS-1:0] resp_rdata,
  output logic                          busy
);

  localparam int BLK_W      = WORD_W * BLOCK_WORDS;
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int WA_W       = BLOCK_ADDR_W + $clog2(BLOCK_WORDS);
  localparam int FIRST_BEAT = LATENCY - BLOCK_WORDS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [BLOCK_ADDR_W-1:0] addr_q, addr_d;
  logic [BLK_W-1:0]        wdata_q, wdata_d;
  logic [BLK_W-1:0]        rdata_q, rdata_d;

  logic              ram_en, ram_we;
  logic [WA_W-1:0]   ram_addr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;

  function automatic logic is_beat(input logic [CNT_W-1:0] cnt);
    return int'(cnt) >= FIRST_BEAT;
  endfunction

  function automatic int beat_lsb(input logic [CNT_W-1:0] cnt);
    return (int'(cnt) - FIRST_BEAT) * WORD_W;
  endfunction

  function automatic logic [WA_W-1:0] word_addr(input logic [BLOCK_ADDR_W-1:0] blk,
                                                input logic [CNT_W-1:0] cnt);
    return WA_W'(blk) * WA_W'(BLOCK_WORDS) + WA_W'(int'(cnt) - FIRST_BEAT);
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ACCESS;
          cnt_d   = '0;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      ACCESS: begin
        if (is_beat(cnt_q)) begin
          if (we_q) begin
            // A reset in this cycle must not commit the current beat.
            ram_en    = !rst;
            ram_we    = 1'b1;
            ram_addr  = word_addr(addr_q, cnt_q);
            ram_wdata = wdata_q[beat_lsb(cnt_q) +: WORD_W];
          end else begin
            rdata_d[beat_lsb(cnt_q) +: WORD_W] = ram_rdata;
          end
        end
        if (cnt_q == LAST_CNT) state_d = RESP;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Reads are issued one cycle ahead of their beat so the registered RAM
    // output is ready to be captured at the end of that beat.
    if (state_d == ACCESS && !we_d && is_beat(cnt_d)) begin
      ram_en   = 1'b1;
      ram_we   = 1'b0;
      ram_addr = word_addr(addr_d, cnt_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  mem_word_array #(
    .WORD_W (WORD_W),
    .ADDR_W (WA_W)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_rdata = rdata_q;

endmodule

// File: doc/block_mem_responder.md
# block_mem_responder

Multi-cycle main-memory responder serving whole-block refills and write-backs from the data cache control unit. It sits between the cache and the backing word array. It accepts one block request at a time, spends a fixed LATENCY cycles moving the block one word per cycle, then pulses a one-cycle response. It replaces the cache's blind cycle counting with an explicit completion handshake.

## Interface
- WORD_W, 32, data word width in bits
- BLOCK_WORDS, 4, words per cache block; must be a power of two
- BLOCK_ADDR_W, 8, block address width; memory holds 2**BLOCK_ADDR_W blocks
- LATENCY, 4, cycles spent in ACCESS; must satisfy LATENCY >= BLOCK_WORDS
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  cache presents a request
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = write-back of a dirty block, 0 = refill read
- req_addr  in  BLOCK_ADDR_W  block address
- req_wdata  in  WORD_W*BLOCK_WORDS  write-back block; word 0 in the LSBs
- resp_valid  out  1  one-cycle completion pulse, for both reads and writes
- resp_rdata  out  WORD_W*BLOCK_WORDS  refill block; meaningful only while resp_valid is high after a read
- busy  out  1  high in ACCESS and RESP

## Operation
- States:
  - IDLE: req_ready=1.
  - On req_valid && req_ready: capture req_we, req_addr and req_wdata into internal registers, clear cnt, go to ACCESS.
  - ACCESS: cnt runs 0..LATENCY-1. At cnt==LATENCY-1, go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Beats:
  - ACCESS cycles with cnt >= LATENCY-BLOCK_WORDS each transfer one word.
  - beat = cnt-(LATENCY-BLOCK_WORDS), word address = addr*BLOCK_WORDS + beat, word 0 first.
  - Read: the array word is loaded into resp_rdata slice [beat].
  - Write: latched wdata slice [beat] is written to the array.
- Inputs are sampled only at acceptance. Changes to req_* while busy have no effect.
- req_valid asserted while not ready is simply not accepted. No queueing, no error.
- A write response leaves resp_rdata unchanged from the last read.
- Address arithmetic is unsigned. Word address width is BLOCK_ADDR_W+log2(BLOCK_WORDS), so there is no overflow or wrap.
- Reset values: req_ready=1, resp_valid=0, busy=0, resp_rdata=0, state IDLE, cnt=0.
- Array contents are not affected by reset.
- Reset during ACCESS aborts the request immediately with no resp_valid.
  - Words already written by a partial write-back stay written.
  - A partial refill is discarded: resp_rdata goes to 0.

## Timing
- Acceptance edge E0 moves the block into ACCESS. ACCESS covers cycles E0..E(LATENCY).
- resp_valid is high in the cycle after edge E(LATENCY). Request-to-response latency is LATENCY+1 cycles.
- IDLE is re-entered after E(LATENCY+1). The earliest next acceptance edge is E(LATENCY+2).
- With the defaults (LATENCY=4, BLOCK_WORDS=4) every ACCESS cycle is a beat, and resp_valid appears 5 cycles after acceptance.
- The array is read synchronously, one word per cycle. No combinational path exists from req_* to resp_*.

## Structure
- Package mem_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - default WORD_W, BLOCK_WORDS, BLOCK_ADDR_W and LATENCY constants
  - block data type
- Sub-module mem_word_array: single-port synchronous word RAM with one read or write per cycle. It holds the 2**(BLOCK_ADDR_W)*BLOCK_WORDS words, and the bench preloads it via a hierarchical task.
- Top level contains the FSM, cnt, request latches and the resp_rdata assembly register.

## Test plan
- Reset, then idle: req_ready=1, resp_valid=0, busy=0, resp_rdata=0 for 10 cycles.
- Preload block 3 with words 0xA0..0xA3. Read addr 3: resp_valid exactly 5 cycles after acceptance, resp_rdata = {0xA3,0xA2,0xA1,0xA0}, single-cycle pulse.
- Write addr 7 with {0xD3,0xD2,0xD1,0xD0}, then read addr 7: returns the same block. resp_rdata during the write's resp_valid still holds the block-3 data.
- Hold req_valid high continuously with alternating addresses: acceptances spaced exactly LATENCY+2=6 cycles apart. Changing req_addr mid-ACCESS does not alter the result.
- Assert rst at cnt=2 of a write of {0xE3..0xE0} to addr 9 over the preloaded 0x90..0x93:
  - no resp_valid
  - state returns to IDLE
  - block 9 reads back {0x93,0x92,0xE1,0xE0}
- Access block 255 (max addr): read and write round-trip correctly, and blocks 254 and 0 are unaffected.
